// File: rtl/srl_fifo_pkg.sv
// Shared sizing constants and helpers for the SRL-backed FIFO.
package srl_fifo_pkg;

  localparam int unsigned SRL_DEPTH = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned LEVEL_W   = 6;
  localparam int unsigned CAPACITY  = 33;

  typedef logic [LEVEL_W-1:0] level_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  // Oldest SRL entry sits at count-1; wraps harmlessly to 31 when empty.
  function automatic addr_t oldest_addr(input level_t count);
    return addr_t'(count - level_t'(1));
  endfunction

endpackage

// File: rtl/SRLC32E.sv
// 32-deep addressable shift register primitive, one data bit wide, no reset.
module SRLC32E import srl_fifo_pkg::*; #(
  parameter bit IS_CLK_INVERTED = 1'b0
) (
  input  logic              CLK,
  input  logic              CE,
  input  logic              D,
  input  logic [ADDR_W-1:0] A,
  output logic              Q,
  output logic              Q31
);

  logic                 clk_int;
  logic [SRL_DEPTH-1:0] sr_q;

  assign clk_int = CLK ^ IS_CLK_INVERTED;

  always_ff @(posedge clk_int) begin
    if (CE) begin
      sr_q <= {sr_q[SRL_DEPTH-2:0], D};
    end
  end

  assign Q   = sr_q[A];
  assign Q31 = sr_q[SRL_DEPTH-1];

endmodule

// File: rtl/srl_fifo.sv
// FIFO of 32 SRL entries plus a registered output word; capacity 33.
module srl_fifo import srl_fifo_pkg::*; #(
  parameter int unsigned WIDTH           = 8,
  parameter bit          IS_CLK_INVERTED = 1'b0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               WR_VALID,
  output logic               WR_READY,
  input  logic [WIDTH-1:0]   WR_DATA,
  output logic               RD_VALID,
  input  logic               RD_READY,
  output logic [WIDTH-1:0]   RD_DATA,
  output logic [LEVEL_W-1:0] LEVEL
);

  logic             clk_int;
  logic             push;
  logic             pop;
  logic             load;
  addr_t            srl_addr;
  logic [WIDTH-1:0] srl_q;
  logic [WIDTH-1:0] unused_q31;

  level_t           srl_count_q, srl_count_d;
  level_t           level_q, level_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_ready_q, wr_ready_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  assign clk_int  = CLK ^ IS_CLK_INVERTED;
  assign srl_addr = oldest_addr(srl_count_q);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    SRLC32E #(
      .IS_CLK_INVERTED(IS_CLK_INVERTED)
    ) u_srl (
      .CLK(CLK),
      .CE (push),
      .D  (WR_DATA[i]),
      .A  (srl_addr),
      .Q  (srl_q[i]),
      .Q31(unused_q31[i])
    );
  end

  always_comb begin
    push        = WR_VALID && wr_ready_q;
    pop         = rd_valid_q && RD_READY;
    // Refill the output word whenever it is empty or being consumed this edge.
    load        = (srl_count_q != '0) && (!rd_valid_q || pop);
    srl_count_d = srl_count_q + level_t'(push) - level_t'(load);
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    if (load) begin
      rd_data_d  = srl_q;
      rd_valid_d = 1'b1;
    end else if (pop) begin
      rd_valid_d = 1'b0;
    end
    level_d    = srl_count_d + level_t'(rd_valid_d);
    wr_ready_d = srl_count_d < level_t'(SRL_DEPTH);
  end

  always_ff @(posedge clk_int or negedge RST_N) begin
    if (!RST_N) begin
      srl_count_q <= '0;
      level_q     <= '0;
      rd_valid_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      srl_count_q <= srl_count_d;
      level_q     <= level_d;
      rd_valid_q  <= rd_valid_d;
      wr_ready_q  <= wr_ready_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign WR_READY = wr_ready_q;
  assign RD_VALID = rd_valid_q;
  assign RD_DATA  = rd_data_q;
  assign LEVEL    = level_q;

  a_count_bound: assert property (@(posedge clk_int) disable iff (!RST_N)
    srl_count_q <= level_t'(SRL_DEPTH));
  a_level_bound: assert property (@(posedge clk_int) disable iff (!RST_N)
    level_q <= level_t'(CAPACITY));

endmodule
